// File: rtl/alu_32bit_divider.sv
// 32-bit iterative restoring divider, signed (DIV) and unsigned (DIVU).
// One operation takes 33 busy cycles: 32 restoring steps on operand
// magnitudes, then one cycle of sign fix-up and result registration.
module alu_32bit_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divzero,
    output logic        overf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;

    // Operand captures made when a request is accepted
    logic [31:0] a_raw_reg;     // untouched dividend, returned on divide-by-zero
    logic [31:0] bmag_reg;      // divisor magnitude
    logic        qneg_reg;      // quotient must be negated in FIX
    logic        rneg_reg;      // remainder must be negated in FIX
    logic        dz_reg;
    logic        ov_reg;

    // Restoring-division working registers
    logic [31:0] prem_reg;      // partial remainder
    logic [31:0] dvd_reg;       // dividend bits shifting out, quotient bits shifting in

    // Registered result outputs
    logic [31:0] quotient_reg, remainder_reg;
    logic        divzero_reg, overf_reg, done_reg;

    // Operand magnitudes; 0x80000000 negates to itself, which read as
    // unsigned is exactly the magnitude we need.
    logic [31:0] amag, bmag;
    logic        sgn_a, sgn_b;

    // One restoring step
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        trial_ge;
    logic [31:0] step_rem;
    logic [31:0] step_dvd;

    // Magnitude selection at the input boundary
    always_comb begin
        sgn_a = sign & a[31];
        sgn_b = sign & b[31];
        amag  = sgn_a ? (~a + 32'd1) : a;
        bmag  = sgn_b ? (~b + 32'd1) : b;
    end

    // Shift, 33-bit trial subtract, keep or restore
    always_comb begin
        shifted  = {prem_reg, dvd_reg[31]};
        trial    = shifted - {1'b0, bmag_reg};
        // A set top bit means shifted exceeds any 32-bit divisor; otherwise
        // the top bit of the 33-bit difference is the borrow.
        trial_ge = shifted[32] | ~trial[32];
        step_rem = trial_ge ? trial[31:0] : shifted[31:0];
        step_dvd = {dvd_reg[30:0], trial_ge};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and busy decode
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= 5'd0;
            a_raw_reg     <= 32'd0;
            bmag_reg      <= 32'd0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            ov_reg        <= 1'b0;
            prem_reg      <= 32'd0;
            dvd_reg       <= 32'd0;
            quotient_reg  <= 32'd0;
            remainder_reg <= 32'd0;
            divzero_reg   <= 1'b0;
            overf_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg   <= 5'd0;
                        a_raw_reg <= a;
                        bmag_reg  <= bmag;
                        dvd_reg   <= amag;
                        prem_reg  <= 32'd0;
                        qneg_reg  <= sgn_a ^ sgn_b;
                        rneg_reg  <= sgn_a;
                        dz_reg    <= (b == 32'd0);
                        ov_reg    <= sign && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                    end
                end
                RUN: begin
                    prem_reg <= step_rem;
                    dvd_reg  <= step_dvd;
                    cnt_reg  <= cnt_reg + 5'd1;
                end
                FIX: begin
                    done_reg    <= 1'b1;
                    divzero_reg <= dz_reg;
                    overf_reg   <= ov_reg;
                    if (dz_reg) begin
                        // Divide-by-zero bypasses sign fix-up entirely
                        quotient_reg  <= 32'hFFFF_FFFF;
                        remainder_reg <= a_raw_reg;
                    end else begin
                        quotient_reg  <= qneg_reg ? (~dvd_reg + 32'd1) : dvd_reg;
                        remainder_reg <= rneg_reg ? (~prem_reg + 32'd1) : prem_reg;
                    end
                end
                default: begin
                    cnt_reg <= 5'd0;
                end
            endcase
        end
    end

    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign divzero   = divzero_reg;
    assign overf     = overf_reg;

endmodule

// File: tb/tb_alu_32bit_divider.sv
// Self-checking bench for alu_32bit_divider: a latency/arithmetic reference
// model compared every cycle, plus literal expectations per directed vector.
module tb_alu_32bit_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divzero;
    logic        overf;

    int errors = 0;
    int checks = 0;

    alu_32bit_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .divzero  (divzero),
        .overf    (overf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } res_t;

    // Arithmetic reference from the result rules, using plain integer math
    function automatic res_t model_div(input logic s, input logic [31:0] x, input logic [31:0] y);
        res_t   res;
        longint sx, sy, sq, sr;
        res = '0;
        if (y == 32'd0) begin
            res.q  = 32'hFFFF_FFFF;
            res.r  = x;
            res.dz = 1'b1;
        end else if (!s) begin
            res.q = x / y;
            res.r = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            res.q  = 32'h8000_0000;
            res.r  = 32'd0;
            res.ov = 1'b1;
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            sq = sx / sy;
            sr = sx - sq * sy;
            res.q = sq[31:0];
            res.r = sr[31:0];
        end
        return res;
    endfunction

    // Cycle model: an accepted request produces its result 33 edges later
    int   m_left = 0;
    logic m_done = 1'b0;
    res_t m_out  = '0;
    res_t m_pend = '0;

    // Reference model update on each rising edge
    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_out  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_pend <= model_div(sign, a, b);
                    m_left <= 33;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_out  <= m_pend;
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("busy",      {31'd0, busy},    {31'd0, m_left != 0});
        chk("done",      {31'd0, done},    {31'd0, m_done});
        chk("quotient",  quotient,         m_out.q);
        chk("remainder", remainder,        m_out.r);
        chk("divzero",   {31'd0, divzero}, {31'd0, m_out.dz});
        chk("overf",     {31'd0, overf},   {31'd0, m_out.ov});
    end

    // Present a request for one rising edge; returns on the following falling edge
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        sign  = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; reports how many falling edges it took
    task automatic wait_done(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done within 60 cycles, expected done");
        end
    endtask

    task automatic expect_lit(input string nm, input logic [31:0] q, input logic [31:0] r,
                              input logic dz, input logic ov);
        chk({nm, "_q"},  quotient,  q);
        chk({nm, "_r"},  remainder, r);
        chk({nm, "_dz"}, {31'd0, divzero}, {31'd0, dz});
        chk({nm, "_ov"}, {31'd0, overf},   {31'd0, ov});
        $display("op %s: sign=%0b a=%h b=%h -> q=%h r=%h dz=%0b ov=%0b",
                 nm, sign, a, b, quotient, remainder, divzero, overf);
    endtask

    // Full operation with literal result and latency expectations
    task automatic run(input string nm, input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
        bit ok;
        int cyc;
        issue(s, x, y);
        wait_done(ok, cyc);
        if (ok) begin
            chk({nm, "_latency"}, cyc, 32'd33);
            expect_lit(nm, q, r, dz, ov);
        end
    endtask

    initial begin
        bit ok;
        int cyc;
        int seen;

        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_q",    quotient,      32'd0);

        // First start on the very first edge with rst low
        rst = 1'b0;
        run("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0);
        run("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
        run("u_m7_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0);
        run("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1);
        run("u_ovf",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0);
        run("u_dz",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0);
        run("s_dz",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b0);
        run("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0);
        run("s_m7_m2",  1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0);
        run("s_min_2",  1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0);
        run("u_big",    1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0);

        // Start while busy is ignored
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(1'b0, 32'd9, 32'd3);
        wait_done(ok, cyc);
        if (ok) begin
            chk("ignored_latency", cyc, 32'd28);
            expect_lit("ignored", 32'd14, 32'd2, 1'b0, 1'b0);
        end

        // Reset at edge n+10 aborts the operation
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q",    quotient,      32'd0);
        chk("abort_r",    remainder,     32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 32'd0);
        $display("op abort: reset mid-run, done pulses seen=%0d", seen);

        // Back-to-back: new request held during the done cycle
        issue(1'b0, 32'd100, 32'd7);
        wait_done(ok, cyc);
        if (ok) begin
            expect_lit("b2b_first", 32'd14, 32'd2, 1'b0, 1'b0);
            issue(1'b0, 32'hFFFF_FFFF, 32'h10);
            wait_done(ok, cyc);
            if (ok) begin
                chk("b2b_latency", cyc, 32'd33);
                expect_lit("b2b_second", 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
